// File: rtl/complex_mult_seq.sv
// Complex product (a_i + j a_q)(b_i + j b_q) on one shared signed multiplier, four partial products.
// Latency: 4 cycles accept edge to dout_valid; best case one result per 6 cycles.
// Backpressure: result held in OUT until dout_ready; din_ready low outside IDLE. CMS_CONJ_EN adds conj_b (B conjugated).
module complex_mult_seq #(
    parameter int DINA_WIDTH = 8,
    parameter int DINB_WIDTH = 8,
    localparam int MULT_WIDTH = DINA_WIDTH + DINB_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic signed [DINA_WIDTH-1:0] dina_i,
    input  logic signed [DINA_WIDTH-1:0] dina_q,
    input  logic signed [DINB_WIDTH-1:0] dinb_i,
    input  logic signed [DINB_WIDTH-1:0] dinb_q,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic signed [MULT_WIDTH-1:0] mult_i,
    output logic signed [MULT_WIDTH-1:0] mult_q,
`ifdef CMS_CONJ_EN
    input  logic                         conj_b,
`endif
    output logic                         busy
);
    localparam int PW = DINA_WIDTH + DINB_WIDTH;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] P0   = 3'd1;
    localparam logic [2:0] P1   = 3'd2;
    localparam logic [2:0] P2   = 3'd3;
    localparam logic [2:0] P3   = 3'd4;
    localparam logic [2:0] OUT  = 3'd5;

    logic [2:0]                   state_q, state_d;
    logic                         init_q;
    logic signed [DINA_WIDTH-1:0] ai_q, aq_q;
    logic signed [DINB_WIDTH-1:0] bi_q, bq_q;
    logic signed [MULT_WIDTH-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic signed [MULT_WIDTH-1:0] res_i_q, res_q_q;
    logic signed [DINA_WIDTH-1:0] mul_a;
    logic signed [DINB_WIDTH-1:0] mul_b;
    logic signed [PW-1:0]         prod;
    logic signed [MULT_WIDTH-1:0] prod_x;
    logic                         conj;
    logic                         accept;

    // init_q keeps din_ready low until the first edge after reset release
    assign din_ready  = init_q && (state_q == IDLE);
    assign accept     = din_valid && din_ready;
    assign dout_valid = (state_q == OUT);
    assign busy       = (state_q != IDLE);
    assign mult_i     = res_i_q;
    assign mult_q     = res_q_q;

`ifdef CMS_CONJ_EN
    logic conj_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            conj_q <= 1'b0;
        else if (accept)
            conj_q <= conj_b;
    end
    assign conj = conj_q;
`else
    assign conj = 1'b0;
`endif

    // P0: ai*bi, P1: aq*bq, P2: ai*bq, P3: aq*bi
    assign mul_a  = (state_q == P0 || state_q == P2) ? ai_q : aq_q;
    assign mul_b  = (state_q == P0 || state_q == P3) ? bi_q : bq_q;
    assign prod   = PW'(mul_a) * PW'(mul_b);
    assign prod_x = {prod[PW-1], prod};

    always_comb begin
        state_d = state_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        case (state_q)
            IDLE: if (accept) state_d = P0;
            P0: begin
                acc_i_d = prod_x;
                state_d = P1;
            end
            P1: begin
                acc_i_d = conj ? acc_i_q + prod_x : acc_i_q - prod_x;
                state_d = P2;
            end
            P2: begin
                acc_q_d = conj ? -prod_x : prod_x;
                state_d = P3;
            end
            P3: begin
                acc_q_d = acc_q_q + prod_x;
                state_d = OUT;
            end
            OUT: if (dout_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
            ai_q    <= '0;
            aq_q    <= '0;
            bi_q    <= '0;
            bq_q    <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            res_i_q <= '0;
            res_q_q <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            if (accept) begin
                ai_q <= dina_i;
                aq_q <= dina_q;
                bi_q <= dinb_i;
                bq_q <= dinb_q;
            end
            // separate result register so outputs survive the next operation's P0
            if (state_q == P3) begin
                res_i_q <= acc_i_q;
                res_q_q <= acc_q_d;
            end
        end
    end
endmodule

// File: tb/tb_complex_mult_seq.sv
// Directed bench for complex_mult_seq: hand-computed products, handshake timing, backpressure, reset, sweep.
module tb_complex_mult_seq;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               din_valid = 1'b0;
    logic               dout_ready = 1'b1;
    logic signed [7:0]  dina_i = '0, dina_q = '0, dinb_i = '0, dinb_q = '0;
    logic               din_ready, dout_valid, busy;
    logic signed [16:0] mult_i, mult_q;
`ifdef CMS_CONJ_EN
    logic               conj_b = 1'b0;
`endif

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    complex_mult_seq #(.DINA_WIDTH(8), .DINB_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dina_i     (dina_i),
        .dina_q     (dina_q),
        .dinb_i     (dinb_i),
        .dinb_q     (dinb_q),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .mult_i     (mult_i),
        .mult_q     (mult_q),
`ifdef CMS_CONJ_EN
        .conj_b     (conj_b),
`endif
        .busy       (busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sv(input int k, input int sh);
        case ((k >> sh) & 3)
            0:       return 4;
            1:       return 7;
            2:       return 11;
            default: return 15;
        endcase
    endfunction

    task automatic set_ops(input int ai, input int aq, input int bi, input int bq);
        dina_i = 8'(ai);
        dina_q = 8'(aq);
        dinb_i = 8'(bi);
        dinb_q = 8'(bq);
    endtask

    // Present operands, wait for accept, scramble inputs, then wait for dout_valid.
    task automatic run_op(input int ai, input int aq, input int bi, input int bq,
                          output int lat, output int bcnt);
        int w;
        set_ops(ai, aq, bi, bq);
        din_valid = 1'b1;
        w = 0;
        while (!din_ready && w < 20) begin
            tick();
            w++;
        end
        chk("accept_wait", int'(din_ready), 1);
        tick();
        din_valid = 1'b0;
        dina_i = ~dina_i;
        dina_q = ~dina_q;
        dinb_i = ~dinb_i;
        dinb_q = ~dinb_q;
        lat  = 0;
        bcnt = int'(busy);
        while (!dout_valid && lat < 20) begin
            tick();
            lat++;
            bcnt += int'(busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt, bad;
        logic signed [16:0] hi, hq;
        int acc_n, done_n, cyc, last_acc;
        bit a_now, o_now;

        #23;
        chk("rst_din_ready", int'(din_ready), 0);
        chk("rst_dout_valid", int'(dout_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mult_i", int'(mult_i), 0);
        chk("rst_mult_q", int'(mult_q), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_din_ready", int'(din_ready), 1);

        run_op(3, 4, 5, 6, lat, bcnt);
        chk("basic_lat", lat, 4);
        chk("basic_i", int'(mult_i), -9);
        chk("basic_q", int'(mult_q), 38);
        chk("basic_busy_cycles", bcnt, 5);
        tick();
        chk("basic_hs_valid", int'(dout_valid), 0);
        chk("basic_hs_busy", int'(busy), 0);
        chk("basic_hs_ready", int'(din_ready), 1);

        run_op(-128, -128, -128, -128, lat, bcnt);
        chk("ext1_i", int'(mult_i), 0);
        chk("ext1_q", int'(mult_q), 32768);
        tick();
        run_op(-128, 127, 127, -128, lat, bcnt);
        chk("ext2_i", int'(mult_i), 0);
        chk("ext2_q", int'(mult_q), 32513);
        tick();

        dout_ready = 1'b0;
        run_op(-7, 2, 3, -5, lat, bcnt);
        chk("bp_lat", lat, 4);
        chk("bp_i", int'(mult_i), -11);
        chk("bp_q", int'(mult_q), 41);
        hi = mult_i;
        hq = mult_q;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (dout_valid !== 1'b1 || mult_i !== hi || mult_q !== hq ||
                din_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        chk("bp_hold_violations", bad, 0);
        dout_ready = 1'b1;
        tick();
        chk("bp_hs_valid", int'(dout_valid), 0);
        chk("bp_hs_ready", int'(din_ready), 1);
        chk("bp_keep_i", int'(mult_i), -11);

        set_ops(9, -3, 4, 6);
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        tick();
        chk("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(dout_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_i", int'(mult_i), 0);
        chk("mid_rst_q", int'(mult_q), 0);
        chk("mid_rst_ready", int'(din_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_no_stale", int'(dout_valid), 0);
        run_op(1, 0, 2, 3, lat, bcnt);
        chk("post_rst_lat", lat, 4);
        chk("post_rst_i", int'(mult_i), 2);
        chk("post_rst_q", int'(mult_q), 3);
        tick();

`ifdef CMS_CONJ_EN
        conj_b = 1'b1;
        run_op(3, 4, 5, 6, lat, bcnt);
        conj_b = 1'b0;
        chk("conj_lat", lat, 4);
        chk("conj_i", int'(mult_i), 39);
        chk("conj_q", int'(mult_q), 2);
        tick();
        run_op(3, 4, 5, 6, lat, bcnt);
        chk("noconj_i", int'(mult_i), -9);
        chk("noconj_q", int'(mult_q), 38);
        tick();
`endif

        // back-to-back sweep with din_valid held high
        acc_n = 0;
        done_n = 0;
        cyc = 0;
        last_acc = -1;
        set_ops(sv(0, 6), sv(0, 4), sv(0, 2), sv(0, 0));
        din_valid = 1'b1;
        dout_ready = 1'b1;
        while (done_n < 256 && cyc < 3000) begin
            a_now = din_valid && din_ready;
            o_now = dout_valid;
            if (o_now) begin
                chk("sweep_i", int'(mult_i),
                    sv(done_n, 6) * sv(done_n, 2) - sv(done_n, 4) * sv(done_n, 0));
                chk("sweep_q", int'(mult_q),
                    sv(done_n, 6) * sv(done_n, 0) + sv(done_n, 4) * sv(done_n, 2));
            end
            tick();
            cyc++;
            if (a_now) begin
                if (last_acc >= 0) chk("sweep_gap", cyc - last_acc, 6);
                last_acc = cyc;
                acc_n++;
                if (acc_n < 256) set_ops(sv(acc_n, 6), sv(acc_n, 4), sv(acc_n, 2), sv(acc_n, 0));
                else din_valid = 1'b0;
            end
            if (o_now) done_n++;
        end
        din_valid = 1'b0;
        chk("sweep_done", done_n, 256);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
